// File: rtl/grf_wb_pkg.sv
// Shared widths, requester ids and arbitration-mode encodings for the
// general register file writeback arbiter.
package grf_wb_pkg;

    localparam int GRF_IDX_W  = 5;
    localparam int GRF_DATA_W = 32;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    typedef enum logic {
        REQ_R0 = 1'b0,
        REQ_R1 = 1'b1
    } req_id_e;

endpackage

// File: rtl/grf_wb_pick.sv
// Combinational grant selection: turns the two valids plus arbitration
// history into a one-hot grant vector {r1, r0}.
module grf_wb_pick
    import grf_wb_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  req_id_e    lastGrant_i,
    input  logic       starveHit_i,
    output logic [1:0] grant_o
);

    req_id_e winner;

    // A lone requester always wins; a tie is settled by the mode policy.
    always_comb begin
        winner  = REQ_R0;
        grant_o = {valid1_i, valid0_i};
        if (valid0_i && valid1_i) begin
            if (PRIO_MODE == PRIO_FIXED) begin
                winner = starveHit_i ? REQ_R1 : REQ_R0;
            end else begin
                winner = (lastGrant_i == REQ_R1) ? REQ_R0 : REQ_R1;
            end
            grant_o = (winner == REQ_R1) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Two-requester writeback arbiter in front of the register file write port;
// the accepted write is registered and presented for exactly one cycle.
module grf_wb_arbiter
    import grf_wb_pkg::*;
#(
    parameter int PRIO_MODE    = PRIO_RR,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Hold,
    input  logic                  r0_valid,
    input  logic                  r1_valid,
    output logic                  r0_ready,
    output logic                  r1_ready,
    input  logic [GRF_IDX_W-1:0]  r0_rw,
    input  logic [GRF_IDX_W-1:0]  r1_rw,
    input  logic [GRF_DATA_W-1:0] r0_wd,
    input  logic [GRF_DATA_W-1:0] r1_wd,
    input  logic [GRF_DATA_W-1:0] r0_wpc,
    input  logic [GRF_DATA_W-1:0] r1_wpc,
    output logic                  WE,
    output logic [GRF_IDX_W-1:0]  RW,
    output logic [GRF_DATA_W-1:0] WD,
    output logic [GRF_DATA_W-1:0] WPC,
    output logic                  pend_valid
);

    localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic                  we_q, we_d;
    logic [GRF_IDX_W-1:0]  rw_q, rw_d;
    logic [GRF_DATA_W-1:0] wd_q, wd_d;
    logic [GRF_DATA_W-1:0] wpc_q, wpc_d;
    req_id_e               lastGrant_q, lastGrant_d;
    logic [STARVE_W-1:0]   starveCnt_q, starveCnt_d;

    logic [1:0]            grant;
    logic                  accept;
    logic [GRF_IDX_W-1:0]  selRw;
    logic [GRF_DATA_W-1:0] selWd;
    logic [GRF_DATA_W-1:0] selWpc;

    grf_wb_pick #(
        .PRIO_MODE (PRIO_MODE)
    ) u_pick (
        .valid0_i    (r0_valid),
        .valid1_i    (r1_valid),
        .lastGrant_i (lastGrant_q),
        .starveHit_i (starveCnt_q == STARVE_MAX),
        .grant_o     (grant)
    );

    // Grants are suppressed during reset and Hold so nothing is accepted then.
    assign r0_ready = grant[0] & ~Hold & Reset;
    assign r1_ready = grant[1] & ~Hold & Reset;
    assign accept   = r0_ready | r1_ready;

    // Writes to index 0 still complete the handshake but never raise WE.
    always_comb begin
        selRw       = r1_ready ? r1_rw  : r0_rw;
        selWd       = r1_ready ? r1_wd  : r0_wd;
        selWpc      = r1_ready ? r1_wpc : r0_wpc;
        we_d        = accept && (selRw != '0);
        rw_d        = accept ? selRw  : rw_q;
        wd_d        = accept ? selWd  : wd_q;
        wpc_d       = accept ? selWpc : wpc_q;
        lastGrant_d = accept ? (r1_ready ? REQ_R1 : REQ_R0) : lastGrant_q;
        starveCnt_d = starveCnt_q;
        if (PRIO_MODE != PRIO_FIXED) begin
            starveCnt_d = '0;
        end else if (!Hold) begin
            if (!r1_valid || r1_ready) begin
                starveCnt_d = '0;
            end else if (starveCnt_q != STARVE_MAX) begin
                starveCnt_d = starveCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            we_q        <= 1'b0;
            rw_q        <= '0;
            wd_q        <= '0;
            wpc_q       <= '0;
            lastGrant_q <= REQ_R1;
            starveCnt_q <= '0;
        end else begin
            we_q        <= we_d;
            rw_q        <= rw_d;
            wd_q        <= wd_d;
            wpc_q       <= wpc_d;
            lastGrant_q <= lastGrant_d;
            starveCnt_q <= starveCnt_d;
        end
    end

    assign WE         = we_q;
    assign RW         = rw_q;
    assign WD         = wd_q;
    assign WPC        = wpc_q;
    assign pend_valid = we_q;

endmodule
